// File: rtl/scan_strobe_decoder.sv
// Digit-scan decoder: ticks on the falling edge of count[TAP] and steps an active-low digit select.
// Optional ghost blanking between digits is enabled by defining SCAN_GHOST_BLANK_EN.
module scan_strobe_decoder #(
   parameter int CNT_W     = 14,
   parameter int TAP       = 13,
   parameter int DIGITS    = 4,
   parameter int DATA_W    = 4,
   parameter int BLANK_CYC = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CNT_W-1:0]           count,
   input  logic                       enable,
   input  logic [DIGITS*DATA_W-1:0]   digits_in,
   output logic                       tick,
   output logic [$clog2(DIGITS)-1:0]  digit_idx,
   output logic [DIGITS-1:0]          anode_n,
   output logic [DATA_W-1:0]          digit_val
);

   localparam int IDX_W = $clog2(DIGITS);

   if (DIGITS < 2 || DIGITS > 8 || TAP < 0 || TAP >= CNT_W || BLANK_CYC < 1) begin : g_param_check
      $error("scan_strobe_decoder: parameter out of range");
   end

   // Whole-slice select so the output never mixes bits of two digits.
   function automatic logic [DATA_W-1:0] pick_digit(input logic [IDX_W-1:0] idx,
                                                    input logic [DIGITS*DATA_W-1:0] d);
      logic [DATA_W-1:0] v;
      v = {DATA_W{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         v = (idx == IDX_W'(i)) ? d[i*DATA_W +: DATA_W] : v;
      end
      return v;
   endfunction

   function automatic logic [DIGITS-1:0] select_n(input logic [IDX_W-1:0] idx);
      return ~(DIGITS'(1) << idx);
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
   endfunction

   logic                     tap_q_r;
   logic                     tick_r;
   logic                     tick_nxt_s;
   logic [IDX_W-1:0]         idx_r;
   logic [IDX_W-1:0]         idx_nxt_s;
   logic [DIGITS-1:0]        anode_r;
   logic [DIGITS-1:0]        anode_nxt_s;
   logic [DATA_W-1:0]        val_r;
   logic [DATA_W-1:0]        val_nxt_s;
   logic [CNT_W-1:0]         count_unused_s;

   assign count_unused_s = count;
   assign tick_nxt_s     = tap_q_r & ~count[TAP] & enable;

`ifdef SCAN_GHOST_BLANK_EN
   localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

   typedef enum logic [0:0] {
      ST_DRIVE = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [BC_W-1:0]   blank_cnt_r;
   logic [BC_W-1:0]   blank_cnt_nxt_s;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_DRIVE;
         blank_cnt_r <= {BC_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         blank_cnt_r <= blank_cnt_nxt_s;
      end
   end

   // Next state: a tick opens the blanking window, disable aborts it
   always_comb begin
      state_nxt_s     = ST_DRIVE;
      blank_cnt_nxt_s = {BC_W{1'b0}};
      case (state_r)
         ST_DRIVE: begin
            if (enable && tick_r) begin
               state_nxt_s     = ST_BLANK;
               blank_cnt_nxt_s = BC_W'(BLANK_CYC - 1);
            end else begin
               state_nxt_s     = ST_DRIVE;
               blank_cnt_nxt_s = {BC_W{1'b0}};
            end
         end
         ST_BLANK: begin
            if (!enable || blank_cnt_r == {BC_W{1'b0}}) begin
               state_nxt_s     = ST_DRIVE;
               blank_cnt_nxt_s = {BC_W{1'b0}};
            end else begin
               state_nxt_s     = ST_BLANK;
               blank_cnt_nxt_s = blank_cnt_r - BC_W'(1);
            end
         end
         default: begin
            state_nxt_s     = ST_DRIVE;
            blank_cnt_nxt_s = {BC_W{1'b0}};
         end
      endcase
   end

   // Output next values; ticks seen while blanking are dropped
   always_comb begin
      idx_nxt_s   = idx_r;
      anode_nxt_s = {DIGITS{1'b1}};
      val_nxt_s   = val_r;
      if (!enable) begin
         anode_nxt_s = {DIGITS{1'b1}};
      end else begin
         case (state_r)
            ST_DRIVE: begin
               if (tick_r) begin
                  anode_nxt_s = {DIGITS{1'b1}};
               end else begin
                  anode_nxt_s = select_n(idx_r);
                  val_nxt_s   = pick_digit(idx_r, digits_in);
               end
            end
            ST_BLANK: begin
               if (blank_cnt_r == {BC_W{1'b0}}) begin
                  idx_nxt_s   = next_idx(idx_r);
                  anode_nxt_s = select_n(idx_nxt_s);
                  val_nxt_s   = pick_digit(idx_nxt_s, digits_in);
               end else begin
                  anode_nxt_s = {DIGITS{1'b1}};
               end
            end
            default: begin
               anode_nxt_s = {DIGITS{1'b1}};
            end
         endcase
      end
   end
`else
   // Output next values; the index advances directly on a tick
   always_comb begin
      idx_nxt_s   = idx_r;
      anode_nxt_s = {DIGITS{1'b1}};
      val_nxt_s   = val_r;
      if (!enable) begin
         anode_nxt_s = {DIGITS{1'b1}};
      end else if (tick_r) begin
         idx_nxt_s   = next_idx(idx_r);
         anode_nxt_s = select_n(idx_nxt_s);
         val_nxt_s   = pick_digit(idx_nxt_s, digits_in);
      end else begin
         anode_nxt_s = select_n(idx_r);
         val_nxt_s   = pick_digit(idx_r, digits_in);
      end
   end
`endif

   // Tap sample, tick strobe and display output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tap_q_r <= 1'b0;
         tick_r  <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
         anode_r <= {DIGITS{1'b1}};
         val_r   <= {DATA_W{1'b0}};
      end else begin
         tap_q_r <= count[TAP];
         tick_r  <= tick_nxt_s;
         idx_r   <= idx_nxt_s;
         anode_r <= anode_nxt_s;
         val_r   <= val_nxt_s;
      end
   end

   assign tick      = tick_r;
   assign digit_idx = idx_r;
   assign anode_n   = anode_r;
   assign digit_val = val_r;

endmodule
